// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts and a
// shift-add multiplier behind an IDLE/RUN/DONE handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryOut,
    output logic             overFlow,
    output logic             negative
);

    localparam int unsigned CW = SHW + 1;
    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_NOR  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [3:0]           op_q, op_nx;
    logic [WIDTH-1:0]     a_q, a_nx;
    logic [WIDTH-1:0]     sh_q, sh_nx;
    logic [2*WIDTH-1:0]   p_q, p_nx;
    logic [CW-1:0]        cnt_q, cnt_nx;
    logic                 ld;
    logic [WIDTH-1:0]     res_nx;
    logic                 co_nx, ov_nx;

    logic [WIDTH:0]       sum, dif, madd;
    logic [WIDTH-1:0]     sh_step;
    logic [2*WIDTH-1:0]   p_step;
    logic [SHW-1:0]       k;

    // Datapath: immediate add/sub on live operands, one shift or multiply step on latched state.
    always_comb begin
        k       = B[SHW-1:0];
        sum     = {1'b0, A} + {1'b0, B};
        dif     = {1'b0, A} + {1'b0, ~B} + W1'(1);
        madd    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : W1'(0));
        p_step  = {madd, p_q[WIDTH-1:1]};
        case (op_q)
            OP_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_step = {1'b0, sh_q[WIDTH-1:1]};
            default: sh_step = {a_q[WIDTH-1], sh_q[WIDTH-1:1]};
        endcase
    end

    // Next-state and result selection; ld marks the edge that enters DONE.
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        a_nx     = a_q;
        sh_nx    = sh_q;
        p_nx     = p_q;
        cnt_nx   = cnt_q;
        ld       = 1'b0;
        res_nx   = '0;
        co_nx    = 1'b0;
        ov_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx    = op;
                    a_nx     = A;
                    state_nx = DONE;
                    ld       = 1'b1;
                    case (op)
                        OP_AND:  res_nx = A & B;
                        OP_OR:   res_nx = A | B;
                        OP_NOR:  res_nx = ~(A | B);
                        OP_XOR:  res_nx = A ^ B;
                        OP_ADD: begin
                            res_nx = sum[WIDTH-1:0];
                            co_nx  = sum[WIDTH];
                            ov_nx  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res_nx = dif[WIDTH-1:0];
                            co_nx  = dif[WIDTH];
                            ov_nx  = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_SLT:  res_nx = WIDTH'($signed(A) < $signed(B));
                        OP_SLTU: res_nx = WIDTH'(A < B);
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (k != '0) begin
                                state_nx = RUN;
                                ld       = 1'b0;
                                sh_nx    = A;
                                cnt_nx   = CW'(k);
                            end else begin
                                res_nx = A;
                            end
                        end
                        OP_MUL: begin
                            state_nx = RUN;
                            ld       = 1'b0;
                            p_nx     = {{WIDTH{1'b0}}, B};
                            cnt_nx   = CW'(WIDTH);
                        end
                        default: res_nx = '0;
                    endcase
                end
            end
            RUN: begin
                cnt_nx = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    p_nx   = p_step;
                    res_nx = p_step[WIDTH-1:0];
                    ov_nx  = |p_step[2*WIDTH-1:WIDTH];
                end else begin
                    sh_nx  = sh_step;
                    res_nx = sh_step;
                end
                if (cnt_q == CW'(1)) begin
                    state_nx = DONE;
                    ld       = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carryOut <= 1'b0;
            overFlow <= 1'b0;
            negative <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            sh_q     <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == IDLE);
            done  <= (state_nx == DONE);
            op_q  <= op_nx;
            a_q   <= a_nx;
            sh_q  <= sh_nx;
            p_q   <= p_nx;
            cnt_q <= cnt_nx;
            if (ld) begin
                result   <= res_nx;
                zero     <= (res_nx == '0);
                negative <= res_nx[WIDTH-1];
                carryOut <= co_nx;
                overFlow <= ov_nx;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done, zero, carry_out, over_flow, negative;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
        .ready(ready), .done(done), .result(result), .zero(zero),
        .carryOut(carry_out), .overFlow(over_flow), .negative(negative)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result, carry, overflow and done latency from plain integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v, output int lat);
        longint ux, uy, sx, sy, t;
        int k;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        k  = int'(y[3:0]);
        r = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (o)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = ~(x | y);
            4'd3: r = x ^ y;
            4'd4: begin
                t = ux + uy; r = t[15:0]; c = (t > 65535);
                v = (sx + sy > 32767) || (sx + sy < -32768);
            end
            4'd5: begin
                t = ux - uy; r = t[15:0]; c = (ux >= uy);
                v = (sx - sy > 32767) || (sx - sy < -32768);
            end
            4'd6: r = (sx < sy) ? 16'd1 : 16'd0;
            4'd7: r = (ux < uy) ? 16'd1 : 16'd0;
            4'd8: begin t = ux << k;  r = t[15:0]; lat = (k == 0) ? 1 : k + 1; end
            4'd9: begin t = ux >> k;  r = t[15:0]; lat = (k == 0) ? 1 : k + 1; end
            4'd10: begin t = sx >>> k; r = t[15:0]; lat = (k == 0) ? 1 : k + 1; end
            4'd11: begin t = ux * uy; r = t[15:0]; v = (t > 65535); lat = 17; end
            default: r = '0;
        endcase
    endtask

    // One transaction: accept, scramble inputs, time done, check outputs and the one-cycle pulse.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic ec, ev;
        int el, cyc;
        model(o, x, y, er, ec, ev, el);
        cyc = 0;
        while (!ready && cyc < 100) begin @(negedge clk); cyc++; end
        check("ready_before", ready, 1);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        cyc = 1;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        check($sformatf("op%0d_latency", o), 64'(cyc), 64'(el));
        check($sformatf("op%0d_ready_in_done", o), ready, 0);
        check($sformatf("op%0d_result", o), result, er);
        check($sformatf("op%0d_zero", o), zero, (er == '0));
        check($sformatf("op%0d_negative", o), negative, er[W-1]);
        check($sformatf("op%0d_carry", o), carry_out, ec);
        check($sformatf("op%0d_overflow", o), over_flow, ev);
        @(negedge clk);
        check($sformatf("op%0d_done_pulse", o), done, 0);
        check($sformatf("op%0d_ready_after", o), ready, 1);
        check($sformatf("op%0d_result_hold", o), result, er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] qa[$], qb[$];
        logic [W-1:0] ea, eb, er;
        logic ec, ev;
        int el, cyc;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, carry_out, over_flow, negative}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd4, 16'h7FFF, 16'h0001);
        check("add_ovf_const", {result, over_flow, negative, carry_out, zero}, {16'h8000, 4'b1100});
        do_op(4'd5, 16'h0005, 16'h0005);
        check("sub_eq_const", {result, zero, carry_out, over_flow}, {16'h0000, 3'b110});
        do_op(4'd5, 16'h0003, 16'h0005);
        check("sub_borrow_const", {result, carry_out, negative}, {16'hFFFE, 2'b01});
        do_op(4'd11, 16'h0003, 16'h0005);
        check("mul_small_const", {result, over_flow}, {16'h000F, 1'b0});
        do_op(4'd11, 16'h0100, 16'h0100);
        check("mul_ovf_const", {result, zero, over_flow}, {16'h0000, 2'b11});
        do_op(4'd8, 16'h1234, 16'h00F0);
        do_op(4'd10, 16'h8001, 16'h000F);
        do_op(4'd9, 16'hFFFF, 16'h000F);
        for (int i = 12; i < 16; i++) do_op(4'(i), 16'($urandom), 16'($urandom));

        // SRA with start held: no re-accept while busy.
        start = 1'b1; op = 4'd10; a = 16'h8000; b = 16'h0004;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 50) begin
            check("sra_no_reaccept", ready, 0);
            @(negedge clk);
            cyc++;
        end
        check("sra_latency", 64'(cyc), 64'd5);
        check("sra_result", result, 16'hF800);
        start = 1'b0;
        @(negedge clk);
        check("sra_ready_back", ready, 1);
        check("sra_done_pulse", done, 0);

        // Reset in cycle 5 of a MUL aborts it.
        start = 1'b1; op = 4'd11; a = 16'h0003; b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin check("abort_no_done", done, 0); @(negedge clk); end
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_flags", {zero, carry_out, over_flow, negative}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        repeat (3) begin check("abort_no_late_done", done, 0); @(negedge clk); end
        do_op(4'd4, 16'h1234, 16'h4321);

        // Back-to-back ADDs with start held: one accept every other cycle.
        for (int i = 0; i < 12; i++) begin
            check("held_ready", ready, (i % 2 == 0));
            check("held_done", done, (i % 2 == 1));
            if (i % 2 == 1 && qa.size() > 0) begin
                ea = qa.pop_front(); eb = qb.pop_front();
                model(4'd4, ea, eb, er, ec, ev, el);
                check("held_result", result, er);
                check("held_carry", carry_out, ec);
            end
            if (i < 11) begin
                start = 1'b1; op = 4'd4; a = 16'($urandom); b = 16'($urandom);
                if (i % 2 == 0) begin qa.push_back(a); qb.push_back(b); end
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        for (int n = 0; n < 200; n++) begin
            logic [3:0] o;
            logic [W-1:0] x, y;
            o = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            y = 16'($urandom);
            case ($urandom_range(0, 5))
                0: x = 16'h8000;
                1: x = 16'hFFFF;
                2: y = 16'h7FFF;
                default: ;
            endcase
            do_op(o, x, y);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width; legal values 8, 16, 32, 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; it SHALL NOT be overridden.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 The block SHALL have port op  input  4  operation select, sampled on accept.
REQ-007 The block SHALL have ports A, B  input  WIDTH  operands, sampled on accept.
REQ-008 The block SHALL have port ready  output  1  high only in IDLE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; result and flags valid from this cycle.
REQ-010 The block SHALL have port result  output  WIDTH  registered result.
REQ-011 The block SHALL have ports zero, carryOut, overFlow, negative  output  1 each  registered flags.

Function
REQ-012 op encoding SHALL be: 0000 AND, 0001 OR, 0010 NOR, 0011 XOR, 0100 ADD, 0101 SUB, 0110 SLT signed, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL (low WIDTH bits of the unsigned product).
REQ-013 Opcodes 1100-1111 SHALL complete as single-cycle ops with result=0, zero=1, other flags 0.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; reset state is IDLE.
REQ-015 Accept: start=1 in IDLE; A, B, op SHALL be latched; later input changes SHALL be ignored until the next accept.
REQ-016 Single-cycle ops (logic, ADD, SUB, SLT, SLTU, illegal, shifts with B[SHW-1:0]=0) SHALL go IDLE->DONE; done=1 exactly one cycle after accept.
REQ-017 Shifts with k=B[SHW-1:0]>0 SHALL iterate one bit per cycle in RUN for k cycles, then go to DONE; done=1 k+1 cycles after accept.
REQ-018 MUL SHALL run shift-add for exactly WIDTH cycles in RUN, then go to DONE; done=1 WIDTH+1 cycles after accept, independent of operand values.
REQ-019 DONE SHALL last one cycle and then return to IDLE; ready=0 in RUN and DONE; start outside IDLE SHALL be ignored, not queued.
REQ-020 result and flags SHALL update only in the cycle done rises and SHALL hold until the next done or reset.
REQ-021 ADD/SUB SHALL be computed as A+B and A+~B+1 at WIDTH+1 bits; carryOut = bit WIDTH (SUB: 1 means no borrow, A>=B unsigned).
REQ-022 overFlow SHALL be signed overflow for ADD/SUB; for MUL, overFlow=1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero; 0 for all other ops.
REQ-023 carryOut SHALL be 0 for all ops other than ADD/SUB.
REQ-024 SLT/SLTU SHALL produce result 1 or 0 in bit 0, upper bits 0.
REQ-025 zero SHALL equal (result==0); negative SHALL equal result[WIDTH-1]; both SHALL apply to every op.
REQ-026 SRA SHALL replicate the latched A[WIDTH-1]; SLL/SRL SHALL fill with 0.

Reset
REQ-027 rst=1 SHALL force state IDLE, result=0, zero=0, carryOut=0, overFlow=0, negative=0, done=0 at the next edge, overriding start.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; ready=1 in the first cycle after rst deasserts.

Verification (WIDTH=16)
REQ-029 ADD A=0x7FFF, B=0x0001 -> done at accept+1; result=0x8000, overFlow=1, negative=1, carryOut=0, zero=0.
REQ-030 SUB A=0x0005, B=0x0005 -> result=0x0000, zero=1, carryOut=1, overFlow=0; SUB 0x0003-0x0005 -> 0xFFFE, carryOut=0, negative=1.
REQ-031 MUL 0x0003*0x0005 -> done exactly at accept+17, result=0x000F, overFlow=0; MUL 0x0100*0x0100 -> result=0x0000, zero=1, overFlow=1.
REQ-032 SRA A=0x8000, B=0x0004, start held high throughout -> done at accept+5, result=0xF800; no second accept before ready returns.
REQ-033 rst pulsed during cycle 5 of a MUL -> no done pulse, result and flags 0, ready=1 after release; a fresh ADD then completes normally.
REQ-034 start held continuously with ADD ops -> one accept every 2 cycles, done alternating 1/0; each result matches its own latched operands.
